npc_ras_unit: RTL and testbench

- Registered next-PC unit for the single-cycle/multi-cycle MIPS32 datapath.
- Holds the PC word address and computes its successor for sequential, branch (BEQ/BNE), jump (J/JAL), register-jump (JR) and return (RET) flow.
- Generalised over address width and adds an exception redirect, a stall hold, and a parametrised return-address stack (RAS) that predicts JR $ra targets.
- Sits between the control unit and instruction memory; pc_out drives IM address bits [31:2].

---
 rtl/npc_ras_unit.sv | 146 ++++++++++++++
 tb/tb_npc_ras_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/npc_ras_unit.sv
`default_nettype none
// ============================================================================
// Module   : npc_ras_unit
// Brief    : Registered next-PC unit for the MIPS32 datapath. Computes the
//            successor word address for sequential, branch, jump, register
//            jump and return flow, with an exception redirect, a stall hold
//            and a circular return-address stack predicting JR $ra targets.
// Revision : 1.0 - initial release
// ============================================================================
module npc_ras_unit #(
    parameter int              ADDR_W    = 30,
    parameter int              RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 'h0000_0C00,
    parameter logic [ADDR_W-1:0] EXC_VEC  = 'h0000_1060
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              exc,
    input  logic [2:0]        nPCOp,
    input  logic              zero,
    input  logic [15:0]       imm16,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] rs_val,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] link_out,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ret_mispredict
);

    localparam int c_PTR_W = $clog2(RAS_DEPTH);
    localparam int c_CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [2:0] c_OP_NML = 3'b000;
    localparam logic [2:0] c_OP_BEQ = 3'b001;
    localparam logic [2:0] c_OP_J   = 3'b010;
    localparam logic [2:0] c_OP_BNE = 3'b011;
    localparam logic [2:0] c_OP_JAL = 3'b100;
    localparam logic [2:0] c_OP_JR  = 3'b101;
    localparam logic [2:0] c_OP_RET = 3'b110;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0]  r_pc;
    logic [c_PTR_W-1:0] r_top;
    logic [c_CNT_W-1:0] r_count;
    logic               r_mispredict;
    logic [ADDR_W-1:0]  r_stack [RAS_DEPTH];

    logic [ADDR_W-1:0]  w_seq;
    logic [ADDR_W-1:0]  w_sext;
    logic [ADDR_W-1:0]  w_branch;
    logic [ADDR_W-1:0]  w_jtarget;
    logic [ADDR_W-1:0]  w_top_val;
    logic [c_PTR_W-1:0] w_push_idx;
    logic               w_empty;
    logic               w_full;
    logic               w_advance;
    logic [ADDR_W-1:0]  w_next;
    logic               w_push;
    logic               w_pop;
    logic               w_mispredict;

    assign w_seq      = r_pc + ADDR_W'(1);
    assign w_sext     = {{(ADDR_W-16){imm16[15]}}, imm16};
    assign w_branch   = w_seq + w_sext;
    assign w_jtarget  = {r_pc[ADDR_W-1:26], imm26};
    assign w_top_val  = r_stack[r_top];
    assign w_push_idx = r_top + c_PTR_W'(1);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_CNT_MAX);
    // Flow ops only take effect when nothing higher priority claims the cycle
    assign w_advance  = !rst && !exc && !stall;

    // Successor selection and RAS push/pop requests
    always_comb begin
        w_next       = w_seq;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_mispredict = 1'b0;
        case (nPCOp)
            c_OP_BEQ: w_next = zero ? w_branch : w_seq;
            c_OP_BNE: w_next = zero ? w_seq : w_branch;
            c_OP_J:   w_next = w_jtarget;
            c_OP_JAL: begin
                w_next = w_jtarget;
                w_push = w_advance;
            end
            c_OP_JR:  w_next = rs_val;
            c_OP_RET: begin
                if (!w_empty) begin
                    // Trust the stack; flag when the register disagrees
                    w_next       = w_top_val;
                    w_pop        = w_advance;
                    w_mispredict = (w_top_val != rs_val);
                end else begin
                    w_next = rs_val;
                end
            end
            default:  w_next = w_seq;
        endcase
    end

    // PC, stack pointers and mispredict pulse with rst > exc > stall priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_top        <= '0;
            r_count      <= '0;
            r_mispredict <= 1'b0;
        end else if (exc) begin
            r_pc         <= EXC_VEC;
            r_mispredict <= 1'b0;
        end else if (stall) begin
            r_mispredict <= 1'b0;
        end else begin
            r_pc         <= w_next;
            r_mispredict <= w_mispredict;
            if (w_push) begin
                r_top <= w_push_idx;
                if (!w_full) begin
                    r_count <= r_count + c_CNT_W'(1);
                end
            end else if (w_pop) begin
                r_top   <= r_top - c_PTR_W'(1);
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Stack storage; a push when full lands on the oldest slot
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_seq;
        end
    end

    assign pc_out         = r_pc;
    assign link_out       = w_seq;
    assign ras_empty      = w_empty;
    assign ras_full       = w_full;
    assign ret_mispredict = r_mispredict;

endmodule
`default_nettype wire

// File: tb/tb_npc_ras_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_npc_ras_unit
// Brief    : Directed vector bench for npc_ras_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_npc_ras_unit;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        exc;
        logic [2:0]  op;
        logic        zero;
        logic [15:0] imm16;
        logic [25:0] imm26;
        logic [29:0] rs;
        logic [29:0] pc;
        logic        empty;
        logic        full;
        logic        mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, stall, exc, zero;
    logic [2:0]  nPCOp;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [29:0] rs_val;
    logic [29:0] pc_out, link_out;
    logic        ras_empty, ras_full, ret_mispredict;

    int n_vec = 0;
    int n_err = 0;
    vec_t q[$];

    always #5 clk = ~clk;

    npc_ras_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .exc(exc), .nPCOp(nPCOp),
        .zero(zero), .imm16(imm16), .imm26(imm26), .rs_val(rs_val),
        .pc_out(pc_out), .link_out(link_out), .ras_empty(ras_empty),
        .ras_full(ras_full), .ret_mispredict(ret_mispredict)
    );

    task automatic v(input logic r, input logic s, input logic e, input logic [2:0] op,
                     input logic z, input logic [15:0] i16, input logic [25:0] i26,
                     input logic [29:0] rs, input logic [29:0] pc,
                     input logic em, input logic fu, input logic mi);
        vec_t t;
        t = '{rst: r, stall: s, exc: e, op: op, zero: z, imm16: i16, imm26: i26,
              rs: rs, pc: pc, empty: em, full: fu, mis: mi};
        q.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        @(negedge clk);
        rst = t.rst; stall = t.stall; exc = t.exc; nPCOp = t.op;
        zero = t.zero; imm16 = t.imm16; imm26 = t.imm26; rs_val = t.rs;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input vec_t t);
        logic [29:0] exp_link;
        exp_link = t.pc + 30'd1;
        n_vec++;
        if (pc_out !== t.pc) begin
            n_err++;
            $display("FAIL %s pc_out: got %h want %h", tag, pc_out, t.pc);
        end
        if (link_out !== exp_link) begin
            n_err++;
            $display("FAIL %s link_out: got %h want %h", tag, link_out, exp_link);
        end
        if (ras_empty !== t.empty) begin
            n_err++;
            $display("FAIL %s ras_empty: got %b want %b", tag, ras_empty, t.empty);
        end
        if (ras_full !== t.full) begin
            n_err++;
            $display("FAIL %s ras_full: got %b want %b", tag, ras_full, t.full);
        end
        if (ret_mispredict !== t.mis) begin
            n_err++;
            $display("FAIL %s ret_mispredict: got %b want %b", tag, ret_mispredict, t.mis);
        end
    endtask

    initial begin
        vec_t h;
        rst = 1'b1; stall = 1'b0; exc = 1'b0; nPCOp = 3'b000; zero = 1'b0;
        imm16 = '0; imm26 = '0; rs_val = '0;

        //  rst s  e  op      z  imm16     imm26      rs            pc            em fu mi
        v(1, 0, 0, 3'b000, 0, 16'h0000, 26'h0,     30'h0,        30'h0000_0C00, 1, 0, 0);
        v(0, 0, 0, 3'b000, 0, 16'h0000, 26'h0,     30'h0,        30'h0000_0C01, 1, 0, 0);
        v(0, 0, 0, 3'b000, 0, 16'h0000, 26'h0,     30'h0,        30'h0000_0C02, 1, 0, 0);
        v(0, 0, 0, 3'b000, 0, 16'h0000, 26'h0,     30'h0,        30'h0000_0C03, 1, 0, 0);
        v(0, 0, 0, 3'b101, 0, 16'h0000, 26'h0,     30'h0C10,     30'h0000_0C10, 1, 0, 0);
        // branches: backward taken, BNE not taken, BNE taken, BEQ not taken
        v(0, 0, 0, 3'b001, 1, 16'hFFFE, 26'h0,     30'h0,        30'h0000_0C0F, 1, 0, 0);
        v(0, 0, 0, 3'b011, 1, 16'h0005, 26'h0,     30'h0,        30'h0000_0C10, 1, 0, 0);
        v(0, 0, 0, 3'b011, 0, 16'h0005, 26'h0,     30'h0,        30'h0000_0C16, 1, 0, 0);
        v(0, 0, 0, 3'b001, 0, 16'h0005, 26'h0,     30'h0,        30'h0000_0C17, 1, 0, 0);
        // JAL then matching RET
        v(0, 0, 0, 3'b101, 0, 16'h0000, 26'h0,     30'h0C20,     30'h0000_0C20, 1, 0, 0);
        v(0, 0, 0, 3'b100, 0, 16'h0000, 26'h100,   30'h0,        30'h0000_0100, 0, 0, 0);
        v(0, 0, 0, 3'b110, 0, 16'h0000, 26'h0,     30'h0C21,     30'h0000_0C21, 1, 0, 0);
        // J and reserved op
        v(0, 0, 0, 3'b010, 0, 16'h0000, 26'h200,   30'h0,        30'h0000_0200, 1, 0, 0);
        v(0, 0, 0, 3'b111, 0, 16'h0000, 26'h0,     30'h0,        30'h0000_0201, 1, 0, 0);
        // five JALs overflow a 4-deep stack; 0x202 is overwritten
        v(0, 0, 0, 3'b100, 0, 16'h0000, 26'h300,   30'h0,        30'h0000_0300, 0, 0, 0);
        v(0, 0, 0, 3'b100, 0, 16'h0000, 26'h400,   30'h0,        30'h0000_0400, 0, 0, 0);
        v(0, 0, 0, 3'b100, 0, 16'h0000, 26'h500,   30'h0,        30'h0000_0500, 0, 0, 0);
        v(0, 0, 0, 3'b100, 0, 16'h0000, 26'h600,   30'h0,        30'h0000_0600, 0, 1, 0);
        v(0, 0, 0, 3'b100, 0, 16'h0000, 26'h700,   30'h0,        30'h0000_0700, 0, 1, 0);
        // four RETs in LIFO order; the second disagrees with rs_val
        v(0, 0, 0, 3'b110, 0, 16'h0000, 26'h0,     30'h0601,     30'h0000_0601, 0, 0, 0);
        v(0, 0, 0, 3'b110, 0, 16'h0000, 26'h0,     30'h0999,     30'h0000_0501, 0, 0, 1);
        v(0, 0, 0, 3'b110, 0, 16'h0000, 26'h0,     30'h0401,     30'h0000_0401, 0, 0, 0);
        v(0, 0, 0, 3'b110, 0, 16'h0000, 26'h0,     30'h0301,     30'h0000_0301, 1, 0, 0);
        v(0, 0, 0, 3'b110, 0, 16'h0000, 26'h0,     30'h0777,     30'h0000_0777, 1, 0, 0);
        // mispredicted return: stack wins, pulse lasts one cycle
        v(0, 0, 0, 3'b101, 0, 16'h0000, 26'h0,     30'h0C20,     30'h0000_0C20, 1, 0, 0);
        v(0, 0, 0, 3'b100, 0, 16'h0000, 26'h100,   30'h0,        30'h0000_0100, 0, 0, 0);
        v(0, 0, 0, 3'b110, 0, 16'h0000, 26'h0,     30'h0C30,     30'h0000_0C21, 1, 0, 1);
        v(0, 0, 0, 3'b000, 0, 16'h0000, 26'h0,     30'h0,        30'h0000_0C22, 1, 0, 0);
        // stall blocks JAL; exc beats stall
        v(0, 1, 0, 3'b100, 0, 16'h0000, 26'h100,   30'h0,        30'h0000_0C22, 1, 0, 0);
        v(0, 1, 1, 3'b000, 0, 16'h0000, 26'h0,     30'h0,        30'h0000_1060, 1, 0, 0);
        v(0, 0, 0, 3'b100, 0, 16'h0000, 26'h50,    30'h0,        30'h0000_0050, 0, 0, 0);
        v(0, 1, 0, 3'b110, 0, 16'h0000, 26'h0,     30'h0,        30'h0000_0050, 0, 0, 0);
        v(0, 0, 1, 3'b110, 0, 16'h0000, 26'h0,     30'h0,        30'h0000_1060, 0, 0, 0);
        v(0, 0, 0, 3'b110, 0, 16'h0000, 26'h0,     30'h1061,     30'h0000_1061, 1, 0, 0);
        // upper PC bits kept by J; wrap to zero
        v(0, 0, 0, 3'b101, 0, 16'h0000, 26'h0,     30'h3FFF_FFFF, 30'h3FFF_FFFF, 1, 0, 0);
        v(0, 0, 0, 3'b010, 0, 16'h0000, 26'h5,     30'h0,        30'h3C00_0005, 1, 0, 0);
        v(0, 0, 0, 3'b101, 0, 16'h0000, 26'h0,     30'h3FFF_FFFF, 30'h3FFF_FFFF, 1, 0, 0);
        v(0, 0, 0, 3'b000, 0, 16'h0000, 26'h0,     30'h0,        30'h0000_0000, 1, 0, 0);
        // reset during stall and exc clears the stack
        v(0, 0, 0, 3'b100, 0, 16'h0000, 26'h0,     30'h0,        30'h0000_0000, 0, 0, 0);
        v(1, 1, 1, 3'b100, 0, 16'h0000, 26'h0,     30'h0,        30'h0000_0C00, 1, 0, 0);

        foreach (q[i]) begin
            drive(q[i]);
            check($sformatf("vec%0d", i), q[i]);
        end

        // Multi-cycle hold: taken BEQ stalled three cycles, link stays valid
        h = '{rst: 0, stall: 1, exc: 0, op: 3'b001, zero: 1, imm16: 16'h0010, imm26: 26'h0,
              rs: 30'h0, pc: 30'h0000_0C00, empty: 1, full: 0, mis: 0};
        for (int k = 0; k < 3; k++) begin
            drive(h);
            check($sformatf("hold%0d", k), h);
        end
        // Released: branch target seq 0xC01 + 0x10
        h.stall = 1'b0;
        h.pc    = 30'h0000_0C11;
        drive(h);
        check("release", h);

        // Mispredict pulse suppressed by a stall on the following cycle
        h = '{rst: 0, stall: 0, exc: 0, op: 3'b100, zero: 0, imm16: 16'h0, imm26: 26'h80,
              rs: 30'h0, pc: 30'h0000_0080, empty: 0, full: 0, mis: 0};
        drive(h);
        check("jal2", h);
        h.op = 3'b110; h.rs = 30'h0; h.pc = 30'h0000_0C12; h.empty = 1; h.mis = 1;
        drive(h);
        check("ret_mis", h);
        h.stall = 1'b1; h.mis = 0;
        drive(h);
        check("mis_clear", h);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
